// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: takes WIDTH-bit words on valid/ready
// and streams them one bit per clock, gap-free across word boundaries.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_last;
  logic             w_accept;
  logic             w_step;
  logic             w_stop;
  logic             w_head_new;
  logic             w_head_cur;
  logic [WIDTH-1:0] w_rest_new;
  logic [WIDTH-1:0] w_rest_cur;

  assign w_last     = (r_state == SHIFT) && (r_cnt == LAST);
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;
  assign w_step     = (r_state == SHIFT) && !w_last;
  assign w_stop     = w_last && !load_valid;

  // r_shreg holds only the bits not yet presented, next bit at the head
  assign w_head_new = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign w_rest_new = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
  assign w_head_cur = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_rest_cur = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      unique case (1'b1)
        w_accept: begin
          r_state      <= SHIFT;
          r_shreg      <= w_rest_new;
          r_cnt        <= '0;
          r_dout       <= w_head_new;
          r_dout_valid <= 1'b1;
          r_busy       <= 1'b1;
          r_frame_done <= 1'b0;
        end
        w_step: begin
          r_shreg      <= w_rest_cur;
          r_cnt        <= r_cnt + 1'b1;
          r_dout       <= w_head_cur;
          r_frame_done <= (r_cnt == PENULT);
        end
        w_stop: begin
          r_state      <= IDLE;
          r_shreg      <= '0;
          r_cnt        <= '0;
          r_dout       <= IDLE_BIT;
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: word-level model checked every cycle
// plus literal waveform expectations for the directed scenarios.
module tb_serial_word_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_valid = 1'b0;

  logic m_ready, m_dout, m_dv, m_busy, m_fd;
  logic l_ready, l_dout, l_dv, l_busy, l_fd;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_ready), .dout(m_dout), .dout_valid(m_dv),
    .busy(m_busy), .frame_done(m_fd)
  );

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .load_data(load_data), .load_valid(load_valid),
    .load_ready(l_ready), .dout(l_dout), .dout_valid(l_dv),
    .busy(l_busy), .frame_done(l_fd)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: current word and index of the bit on the wire
  logic [7:0] mw = 8'h00;
  int         midx = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      midx = -1;
      mw   = 8'h00;
    end else if (load_valid && (midx < 0 || midx == 7)) begin
      mw   = load_data;
      midx = 0;
    end else if (midx >= 0 && midx < 7) begin
      midx = midx + 1;
    end else begin
      midx = -1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic act, eb, em, el, er;
      act = (midx >= 0);
      em  = act ? mw[7 - midx] : 1'b0;
      el  = act ? mw[midx] : 1'b0;
      eb  = act && (midx == 7);
      er  = !act || (midx == 7);
      chk("msb dout", {31'd0, m_dout}, {31'd0, em});
      chk("msb dout_valid", {31'd0, m_dv}, {31'd0, act});
      chk("msb busy", {31'd0, m_busy}, {31'd0, act});
      chk("msb frame_done", {31'd0, m_fd}, {31'd0, eb});
      chk("msb load_ready", {31'd0, m_ready}, {31'd0, er});
      chk("lsb dout", {31'd0, l_dout}, {31'd0, el});
      chk("lsb dout_valid", {31'd0, l_dv}, {31'd0, act});
      chk("lsb frame_done", {31'd0, l_fd}, {31'd0, eb});
      chk("lsb load_ready", {31'd0, l_ready}, {31'd0, er});
    end
  end

  // Per-cycle log plus a 11011 overlapping Mealy detector on the msb stream
  logic       lg_dout [0:1023];
  logic       lg_ldout[0:1023];
  logic       lg_dv   [0:1023];
  logic       lg_busy [0:1023];
  logic       lg_fd   [0:1023];
  logic       lg_rdy  [0:1023];
  logic       lg_det  [0:1023];
  logic [4:0] hist = 5'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) hist = 5'd0;
    else hist = {hist[3:0], m_dout};
    lg_dout[cyc]  = m_dout;
    lg_ldout[cyc] = l_dout;
    lg_dv[cyc]    = m_dv;
    lg_busy[cyc]  = m_busy;
    lg_fd[cyc]    = m_fd;
    lg_rdy[cyc]   = m_ready;
    lg_det[cyc]   = (hist == 5'b11011);
  end

  function automatic logic [31:0] pk(input int sel, input int s, input int n);
    logic [31:0] r;
    logic        b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      case (sel)
        0: b = lg_dout[s + i];
        1: b = lg_ldout[s + i];
        2: b = lg_dv[s + i];
        3: b = lg_fd[s + i];
        4: b = lg_rdy[s + i];
        default: b = lg_det[s + i];
      endcase
      r = {r[30:0], b};
    end
    return r;
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    load_data  = d;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    load_data  = a;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    load_data = b;
    repeat (8) @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset outs msb", {27'd0, m_dout, m_dv, m_busy, m_fd, m_ready}, 32'h1);
    chk("reset outs lsb", {27'd0, l_dout, l_dv, l_busy, l_fd, l_ready}, 32'h1);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    send(8'b11011000);
    repeat (10) @(posedge clk);
    chk("t1 dout", pk(0, t0 + 1, 8), 32'hD8);
    chk("t1 lsb dout", pk(1, t0 + 1, 8), 32'b00011011);
    chk("t1 frame_done", pk(3, t0 + 1, 9), 32'b000000010);
    chk("t1 ready c1..7", pk(4, t0 + 1, 7), 32'h0);
    chk("t1 c9 dout/dv/busy",
        {29'd0, lg_dout[t0 + 9], lg_dv[t0 + 9], lg_busy[t0 + 9]}, 32'h0);
    chk("t1 detector", pk(5, t0 + 1, 9), 32'b000010000);

    send2(8'hA5, 8'h3C);
    repeat (10) @(posedge clk);
    chk("t2 dout", pk(0, t0 + 1, 16), 32'hA53C);
    chk("t2 dout_valid", pk(2, t0 + 1, 17), 32'h1FFFE);
    chk("t2 frame_done", pk(3, t0 + 1, 16), 32'h0101);

    send2(8'b00000011, 8'b01100000);
    repeat (10) @(posedge clk);
    chk("t3 dout", pk(0, t0 + 1, 16), 32'h0360);
    chk("t3 detector", pk(5, t0 + 1, 17), 32'h00040);

    send(8'h01);
    repeat (10) @(posedge clk);
    chk("t4 lsb dout", pk(1, t0 + 1, 8), 32'b10000000);
    chk("t4 msb dout", pk(0, t0 + 1, 8), 32'b00000001);

    send(8'hFF);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5 rst msb", {27'd0, m_dout, m_dv, m_busy, m_fd, m_ready}, 32'h1);
    chk("t5 rst lsb", {27'd0, l_dout, l_dv, l_busy, l_fd, l_ready}, 32'h1);
    @(posedge clk);
    #3;
    rst_n      = 1'b1;
    load_data  = 8'h81;
    load_valid = 1'b1;
    chk("t5 pre dout", pk(0, t0 + 1, 5), 32'b11100);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    t0 = cyc - 1;
    repeat (10) @(posedge clk);
    chk("t5 new dout", pk(0, t0 + 1, 9), 32'b100000010);
    chk("t5 new lsb dout", pk(1, t0 + 1, 8), 32'h81);
    chk("t5 new frame_done", pk(3, t0 + 1, 9), 32'b000000010);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
